// File: rtl/cpu_pkg.sv
// Shared constants and helpers for the 8-bit microcontroller datapath.
package cpu_pkg;
  localparam int PM_ADDR_W    = 8;
  localparam int JMP_NIBBLE_W = 4;
  localparam logic [PM_ADDR_W-1:0] RESET_VECTOR = 8'h00;

  typedef logic [PM_ADDR_W-1:0] pm_addr_t;

  function automatic pm_addr_t jump_target(input logic [JMP_NIBBLE_W-1:0] nibble);
    return {nibble, 4'h0};
  endfunction
endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; ignores push when full and pop when empty.
module return_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          sync_reset,
  input  logic          push,
  input  logic          pop,
  input  pm_addr_t      push_data,
  output pm_addr_t      top,
  output logic [PW:0]   ptr,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0][PM_ADDR_W-1:0] mem;
  logic [PW-1:0]                   wr_idx;
  logic [PW-1:0]                   top_idx;

  assign full    = (ptr == (PW+1)'(DEPTH));
  assign empty   = (ptr == '0);
  assign wr_idx  = ptr[PW-1:0];
  // top_idx wraps when empty; top is unused in that case
  assign top_idx = ptr[PW-1:0] - PW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ptr <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      ptr         <= ptr + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/program_sequencer.sv
// Program-memory address generator: PC, priority address mux, return stack.
module program_sequencer
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int PW          = $clog2(STACK_DEPTH)
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic                    jmp,
  input  logic                    jmp_nz,
  input  logic                    dont_jmp,
  input  logic                    call,
  input  logic                    ret,
  input  logic                    hold,
  input  logic [JMP_NIBBLE_W-1:0] jmp_addr,
  output logic [PM_ADDR_W-1:0]    pm_addr,
  output logic [PM_ADDR_W-1:0]    pc,
  output logic [PM_ADDR_W-1:0]    from_PS,
  output logic [PW:0]             stack_ptr,
  output logic                    stack_err
);
  pm_addr_t pc_inc, target, stk_top;
  logic     push, pop, err_set, stk_full, stk_empty;

  assign pc_inc  = pc + 8'd1;
  assign target  = jump_target(jmp_addr);
  assign from_PS = pc;

  // Priority: reset > hold > ret > call > jmp > jmp_nz > increment
  always_comb begin
    pm_addr = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (sync_reset) begin
      pm_addr = RESET_VECTOR;
    end else if (hold) begin
      pm_addr = pc;
    end else if (ret) begin
      if (stk_empty) begin
        err_set = 1'b1;
      end else begin
        pm_addr = stk_top;
        pop     = 1'b1;
      end
    end else if (call) begin
      pm_addr = target;
      if (stk_full) err_set = 1'b1;
      else          push    = 1'b1;
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      pm_addr = target;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc        <= RESET_VECTOR;
      stack_err <= 1'b0;
    end else begin
      pc <= pm_addr;
      if (err_set) stack_err <= 1'b1;
    end
  end

  return_stack #(.DEPTH(STACK_DEPTH), .PW(PW)) u_stack (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push       (push),
    .pop        (pop),
    .push_data  (pc_inc),
    .top        (stk_top),
    .ptr        (stack_ptr),
    .full       (stk_full),
    .empty      (stk_empty)
  );
endmodule
